// File: rtl/vga_sync_if.sv
// VGA timing output bundle.
// The master side (vga_sync) drives every signal; the slave side is the consumer.
interface vga_sync_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_tick;
    logic       frame_tick;
    logic [7:0] frame_cnt;

    modport master (
        output hsync, vsync, video_on, p_tick,
        output pixel_x, pixel_y, line_tick, frame_tick, frame_cnt
    );

    modport slave (
        input hsync, vsync, video_on, p_tick,
        input pixel_x, pixel_y, line_tick, frame_tick, frame_cnt
    );
endinterface

// File: rtl/vga_sync.sv
// VGA sync generator: 2:1 pixel-enable divider, horizontal and vertical counters,
// registered active-low syncs and single-clock line/frame strobes.
// Optional feature: define VGA_SYNC_FRAME_CNT_EN to build an 8-bit frame counter.
// Without it frame_cnt is a constant zero and no counter register exists.
// All porch/display sums must stay below 1024 to fit the 10-bit counters.
module vga_sync #(
    parameter int H_DISP = 640, // visible pixels per line
    parameter int H_FP   = 16,  // horizontal front porch, pixels
    parameter int H_RT   = 96,  // horizontal retrace, pixels
    parameter int H_BP   = 48,  // horizontal back porch, pixels
    parameter int V_DISP = 480, // visible lines per frame
    parameter int V_FP   = 10,  // vertical front porch, lines
    parameter int V_RT   = 2,   // vertical retrace, lines
    parameter int V_BP   = 33   // vertical back porch, lines
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master vga
);

    localparam logic [9:0] H_VIS     = 10'(H_DISP);
    localparam logic [9:0] H_MAX     = 10'(H_DISP + H_FP + H_RT + H_BP - 1);
    localparam logic [9:0] H_SYNC_LO = 10'(H_DISP + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_DISP + H_FP + H_RT - 1);
    localparam logic [9:0] V_VIS     = 10'(V_DISP);
    localparam logic [9:0] V_MAX     = 10'(V_DISP + V_FP + V_RT + V_BP - 1);
    localparam logic [9:0] V_SYNC_LO = 10'(V_DISP + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_DISP + V_FP + V_RT - 1);

    logic       div_q;
    logic [9:0] h_q;
    logic [9:0] v_q;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       hsync_q;
    logic       vsync_q;
    logic       line_tick;
    logic       frame_tick;

    // Pixel enable: toggles every clk, so it is high on every second edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_q <= 1'b0;
        else       div_q <= ~div_q;
    end

    // Next counter position; equals the current one on edges without a pixel enable.
    // NOTE: both outputs get a default first so no path through this block infers a latch.
    always_comb begin
        h_next = h_q;
        v_next = v_q;
        if (div_q) begin
            if (h_q == H_MAX) begin
                h_next = '0;
                v_next = (v_q == V_MAX) ? '0 : v_q + 10'd1;
            end else begin
                h_next = h_q + 10'd1;
            end
        end
    end

    // Counters and syncs advance together; syncs are decoded from the next position
    // so that the registered sync lines up with pixel_x / pixel_y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else if (div_q) begin
            h_q     <= h_next;
            v_q     <= v_next;
            hsync_q <= !((h_next >= H_SYNC_LO) && (h_next <= H_SYNC_HI));
            vsync_q <= !((v_next >= V_SYNC_LO) && (v_next <= V_SYNC_HI));
        end
    end

    assign line_tick  = div_q && (h_q == H_MAX);
    assign frame_tick = line_tick && (v_q == V_MAX);

    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.video_on   = (h_q < H_VIS) && (v_q < V_VIS);
    assign vga.p_tick     = div_q;
    assign vga.pixel_x    = h_q;
    assign vga.pixel_y    = v_q;
    assign vga.line_tick  = line_tick;
    assign vga.frame_tick = frame_tick;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Frame counter for slow effects such as text blink; wraps modulo 256.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           frame_cnt_q <= '0;
        else if (frame_tick) frame_cnt_q <= frame_cnt_q + 8'd1;
    end

    assign vga.frame_cnt = frame_cnt_q;
`else
    assign vga.frame_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboarded bench for vga_sync with a reduced timing set so that whole frames,
// sync windows and wrap-around are reached quickly. The driver pushes the expected
// outputs for each cycle (derived arithmetically from the number of clk edges since
// reset) and a monitor pops and compares them on the falling edge.
`timescale 1ns/1ps
module tb_vga_sync;

    localparam int H_DISP = 6;
    localparam int H_FP   = 2;
    localparam int H_RT   = 2;
    localparam int H_BP   = 2;
    localparam int V_DISP = 4;
    localparam int V_FP   = 1;
    localparam int V_RT   = 2;
    localparam int V_BP   = 1;
    localparam int HT     = H_DISP + H_FP + H_RT + H_BP;
    localparam int VT     = V_DISP + V_FP + V_RT + V_BP;
    localparam int FT     = HT * VT;
    localparam int HS_LO  = H_DISP + H_FP;
    localparam int HS_HI  = H_DISP + H_FP + H_RT - 1;
    localparam int VS_LO  = V_DISP + V_FP;
    localparam int VS_HI  = V_DISP + V_FP + V_RT - 1;
`ifdef VGA_SYNC_FRAME_CNT_EN
    localparam int FRAMES = 257;
`else
    localparam int FRAMES = 3;
`endif

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic       p_tick;
        logic       line_tick;
        logic       frame_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] fc;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vga_sync_if vif ();

    vga_sync #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_RT(H_RT), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_RT(V_RT), .V_BP(V_BP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .vga  (vif)
    );

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    int   n      = 0;   // clk edges seen with reset low since the last reset
    bit   done   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: after cnt edges, cnt/2 pixels have elapsed; position and frame
    // count follow from plain division by the line and frame lengths.
    function automatic obs_t model(input int cnt);
        obs_t o;
        int   p;
        int   pos;
        int   h;
        int   v;
        p   = cnt / 2;
        pos = p % FT;
        h   = pos % HT;
        v   = pos / HT;
        o.p_tick     = (cnt % 2) == 1;
        o.x          = 10'(h);
        o.y          = 10'(v);
        o.hsync      = !(h >= HS_LO && h <= HS_HI);
        o.vsync      = !(v >= VS_LO && v <= VS_HI);
        o.video_on   = (h < H_DISP) && (v < V_DISP);
        o.line_tick  = o.p_tick && (h == HT - 1);
        o.frame_tick = o.line_tick && (v == VT - 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
        o.fc = 8'((p / FT) % 256);
`else
        o.fc = 8'h00;
`endif
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.hsync      = vif.hsync;
        o.vsync      = vif.vsync;
        o.video_on   = vif.video_on;
        o.p_tick     = vif.p_tick;
        o.line_tick  = vif.line_tick;
        o.frame_tick = vif.frame_tick;
        o.x          = vif.pixel_x;
        o.y          = vif.pixel_y;
        o.fc         = vif.frame_cnt;
        return o;
    endfunction

    // One clock of stimulus: reset changes land mid-cycle, before the sampling edge.
    task automatic cycle(input bit set_rst, input bit clr_rst, input bit expect_syncs_low);
        @(posedge clk);
        if (!reset) n++;
        #(1 + $urandom_range(2));
        if (set_rst) begin
            if (expect_syncs_low) begin
                check("pre_reset_hsync_low", 64'(vif.hsync), 64'(0));
                check("pre_reset_vsync_low", 64'(vif.vsync), 64'(0));
            end
            reset = 1'b1;
            n     = 0;
            #1;
            check("async_rst_hsync",   64'(vif.hsync),   64'(1));
            check("async_rst_vsync",   64'(vif.vsync),   64'(1));
            check("async_rst_pixel_x", 64'(vif.pixel_x), 64'(0));
            check("async_rst_pixel_y", 64'(vif.pixel_y), 64'(0));
            check("async_rst_p_tick",  64'(vif.p_tick),  64'(0));
        end
        if (clr_rst) reset = 1'b0;
        exp_q.push_back(model(n));
    endtask

    // Driver
    initial begin
        bit hit;
        #1 reset = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (FRAMES * 2 * FT) cycle(1'b0, 1'b0, 1'b0);

        // Reset while inside both sync pulses: first hsync column on the last vsync row.
        hit = 1'b0;
        for (int i = 0; i < 2 * FT; i++) begin
            obs_t m;
            m = model(n + 1);
            if (int'(m.x) == HS_LO && int'(m.y) == VS_HI) begin
                cycle(1'b1, 1'b0, 1'b1);
                hit = 1'b1;
                break;
            end
            cycle(1'b0, 1'b0, 1'b0);
        end
        check("directed_reset_point_reached", 64'(hit), 64'(1));
        cycle(1'b0, 1'b1, 1'b0);

        // Random reset bursts at random points in the frame.
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(2 * FT + 7, 1)) cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b1, 1'b0, 1'b0);
            repeat ($urandom_range(2, 0)) cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
        end
        repeat (4 * FT + 5) cycle(1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        done = 1'b1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Monitor
    obs_t act_s;
    obs_t exp_s;
    obs_t prev_s;
    bit   prev_ok = 1'b0;
    bit   fell    = 1'b0;
    int   cyc     = 0;
    int   last_lt = -1;
    int   low_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (done) break;
            if (exp_q.size() == 0) continue;
            exp_s = exp_q.pop_front();
            act_s = sample();
            check($sformatf("outputs@n=%0d", n), 64'(act_s), 64'(exp_s));
            if (reset) begin
                prev_ok = 1'b0;
                fell    = 1'b0;
                cyc     = 0;
                last_lt = -1;
                low_cnt = 0;
                continue;
            end
            cyc++;
            if (prev_ok) begin
                check("p_tick_alternates", 64'(act_s.p_tick), 64'(!prev_s.p_tick));
                if (prev_s.hsync && !act_s.hsync) begin
                    check("hsync_fall_x", 64'(act_s.x), 64'(HS_LO));
                    fell    = 1'b1;
                    low_cnt = 0;
                end
                if (!prev_s.hsync && act_s.hsync && fell) begin
                    check("hsync_rise_x", 64'(act_s.x), 64'(HS_HI + 1));
                    check("hsync_low_clks", 64'(low_cnt), 64'(2 * H_RT));
                end
                if (prev_s.video_on && !act_s.video_on)
                    check("video_on_fall_x", 64'(act_s.x), 64'(H_DISP));
            end
            if (!act_s.hsync) low_cnt++;
            if (!act_s.vsync)
                check("vsync_row", 64'(int'(act_s.y) >= VS_LO && int'(act_s.y) <= VS_HI), 64'(1));
            if (act_s.line_tick) begin
                if (last_lt >= 0) check("line_tick_spacing", 64'(cyc - last_lt), 64'(2 * HT));
                last_lt = cyc;
            end
            if (act_s.frame_tick)
                check("frame_tick_pos", 64'({act_s.x, act_s.y}), 64'({10'(HT - 1), 10'(VT - 1)}));
            prev_s  = act_s;
            prev_ok = 1'b1;
        end
    end

    // Watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
